// File: rtl/key_search_ctrl_pkg.sv
// Shared types and constants for the brute-force key search scheduler.
package key_search_pkg;

    localparam int KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ks_state_t;

    localparam logic [63:0] KS_TARGET_DEF = 64'd2697766566672491622;

endpackage

// File: rtl/key_search_ctrl_if.sv
// Job and lane signals of the key search scheduler; slave is the controller side.
interface key_search_ctrl_if #(
    parameter int LANES = 4,
    parameter int KEY_W = 128
) ();
    import key_search_pkg::*;

    // Grants carry no ready: a lane raises lane_req only when it can accept a
    // block, and a lane_gnt pulse is a completed transfer of lane_blk.
    logic                   start;
    logic [63:0]            target;
    logic [KEY_W-1:0]       key_base;
    logic [31:0]            blk_count;
    logic [LANES-1:0]       lane_req;
    logic [LANES-1:0]       lane_hit;
    logic [LANES*KEY_W-1:0] lane_key;
    logic [LANES-1:0]       lane_gnt;
    logic [KEY_W-1:0]       lane_blk;
    logic [63:0]            target_q;
    logic                   lane_abort;
    logic                   busy;
    logic                   rdy;
    logic                   found;
    logic [KEY_W-1:0]       keyout;
    logic [31:0]            issued;
    ks_state_t              state;

    modport master (
        output start, target, key_base, blk_count, lane_req, lane_hit, lane_key,
        input  lane_gnt, lane_blk, target_q, lane_abort, busy, rdy, found,
               keyout, issued, state
    );

    modport slave (
        input  start, target, key_base, blk_count, lane_req, lane_hit, lane_key,
        output lane_gnt, lane_blk, target_q, lane_abort, busy, rdy, found,
               keyout, issued, state
    );
endinterface

// File: rtl/key_search_ctrl_rr_arbiter.sv
// Round-robin single-grant arbiter; the search starts one past the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic [N-1:0]  elig;
    logic          any;
    int            idx;

    assign elig = req & ~mask & {N{en}};

    always_comb begin
        gnt = '0;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!any && elig[idx]) begin
                gnt[idx] = 1'b1;
                win      = idx[PW-1:0];
                any      = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (any) ptr_d = (win == PW'(N-1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/key_search_ctrl.sv
// Key search scheduler: hands key blocks to lanes round-robin and reports the first hit.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int KEY_W    = key_search_pkg::KEY_W,
    parameter int BLK_LOG2 = 16
) (
    input logic                  clk,
    input logic                  rst,
    key_search_ctrl_if.slave     bus
);
    localparam logic [KEY_W-1:0] BLK_STEP = KEY_W'(1) << BLK_LOG2;

    ks_state_t        state_q;
    logic [63:0]      tgt_q;
    logic [KEY_W-1:0] next_key_q, blk_q, keyout_q, hit_key;
    logic [31:0]      count_q, issued_q;
    logic [LANES-1:0] gnt_q, arb_gnt;
    logic             found_q, rdy_q, abort_q, arb_en;

    // A hit in the same cycle as a grant wins, so the arbiter must not move.
    assign arb_en = (state_q == RUN) && !(|bus.lane_hit);

    rr_arbiter #(.N(LANES)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (bus.lane_req),
        .mask (gnt_q),
        .en   (arb_en),
        .gnt  (arb_gnt)
    );

    always_comb begin
        hit_key = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (bus.lane_hit[i]) hit_key = bus.lane_key[i*KEY_W +: KEY_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            next_key_q <= '0;
            blk_q      <= '0;
            keyout_q   <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            gnt_q      <= '0;
            found_q    <= 1'b0;
            rdy_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        tgt_q      <= bus.target;
                        next_key_q <= bus.key_base;
                        count_q    <= bus.blk_count;
                        issued_q   <= '0;
                        found_q    <= 1'b0;
                        keyout_q   <= '0;
                        rdy_q      <= 1'b0;
                        abort_q    <= 1'b0;
                        state_q    <= (bus.blk_count == 32'd0) ? DRAIN : RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (|bus.lane_hit) begin
                        keyout_q <= hit_key;
                        found_q  <= 1'b1;
                        abort_q  <= 1'b1;
                        rdy_q    <= 1'b1;
                        state_q  <= DONE;
                    end else if (state_q == RUN) begin
                        if (|arb_gnt) begin
                            gnt_q      <= arb_gnt;
                            blk_q      <= next_key_q;
                            next_key_q <= next_key_q + BLK_STEP;
                            issued_q   <= issued_q + 32'd1;
                            if (issued_q + 32'd1 == count_q) state_q <= DRAIN;
                        end
                    end else if (&bus.lane_req) begin
                        rdy_q   <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.lane_gnt   = gnt_q;
    assign bus.lane_blk   = blk_q;
    assign bus.target_q   = tgt_q;
    assign bus.lane_abort = abort_q;
    assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.rdy        = rdy_q;
    assign bus.found      = found_q;
    assign bus.keyout     = keyout_q;
    assign bus.issued     = issued_q;
    assign bus.state      = state_q;
endmodule
